// File: rtl/ssd_bcd_scan_display.sv
// rtl/ssd_bcd_scan_display.sv - binary-to-BCD seven-segment scan display driver with hex mode and overflow
module ssd_bcd_scan_display #(
    parameter int BIN_W      = 8,
    parameter int NUM_DIGITS = 4,
    parameter int SCAN_DIV   = 18,
    parameter bit BLANK_LZ   = 1'b1
) (
    input  logic                  Clk,
    input  logic                  Reset,
    input  logic [BIN_W-1:0]      Value,
    input  logic                  Load,
    input  logic                  Hex_Mode,
    input  logic                  Blank,
    output logic                  Busy,
    output logic                  Done,
    output logic                  Overflow,
    output logic [NUM_DIGITS-1:0] An,
    output logic [6:0]            Seg,
    output logic                  Dp
);

    localparam int BCD_W = 4 * NUM_DIGITS;
    localparam int CNT_W = $clog2(BIN_W + 1);
    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SHIFT,
        S_FINISH
    } state_t;

    state_t                  state_q, state_d;
    logic [BIN_W-1:0]        bin_q, bin_d;
    logic [BCD_W-1:0]        bcd_q, bcd_d;
    logic [CNT_W-1:0]        bitcnt_q, bitcnt_d;
    logic                    ovfw_q, ovfw_d;
    logic                    hexw_q, hexw_d;
    logic [BCD_W-1:0]        disp_q, disp_d;
    logic                    ovf_q, ovf_d;
    logic                    hexm_q, hexm_d;
    logic [SCAN_DIV-1:0]     scan_q, scan_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic [NUM_DIGITS-1:0]   an_q, an_d;
    logic [6:0]              seg_q, seg_d;
    logic [BCD_W-1:0]        adj;
    logic [BCD_W-1:0]        hex_ext;
    logic [3:0]              nib;
    logic                    zero_above;

    // Hex mode shows raw nibbles; bits beyond the value width read as zero
    generate
        if (BCD_W > BIN_W) begin : g_hex_pad
            assign hex_ext = {{(BCD_W - BIN_W){1'b0}}, Value};
        end else begin : g_hex_trunc
            assign hex_ext = Value[BCD_W-1:0];
        end
    endgenerate

    function automatic logic [6:0] hex_glyph(input logic [3:0] n);
        logic [6:0] g;
        case (n)
            4'h0: g = 7'b0000001;
            4'h1: g = 7'b1001111;
            4'h2: g = 7'b0010010;
            4'h3: g = 7'b0000110;
            4'h4: g = 7'b1001100;
            4'h5: g = 7'b0100100;
            4'h6: g = 7'b0100000;
            4'h7: g = 7'b0001111;
            4'h8: g = 7'b0000000;
            4'h9: g = 7'b0000100;
            4'hA: g = 7'b0001000;
            4'hB: g = 7'b1100000;
            4'hC: g = 7'b0110001;
            4'hD: g = 7'b1000010;
            4'hE: g = 7'b0110000;
            default: g = 7'b0111000;
        endcase
        return g;
    endfunction

    // Conversion FSM: accept a load, run double-dabble, then publish to the display register
    always_comb begin
        state_d  = state_q;
        bin_d    = bin_q;
        bcd_d    = bcd_q;
        bitcnt_d = bitcnt_q;
        ovfw_d   = ovfw_q;
        hexw_d   = hexw_q;
        disp_d   = disp_q;
        ovf_d    = ovf_q;
        hexm_d   = hexm_q;
        adj      = bcd_q;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (adj[4*i +: 4] >= 4'd5) begin
                adj[4*i +: 4] = adj[4*i +: 4] + 4'd3;
            end
        end
        case (state_q)
            S_IDLE: begin
                if (Load) begin
                    if (Hex_Mode) begin
                        bcd_d   = hex_ext;
                        ovfw_d  = 1'b0;
                        hexw_d  = 1'b1;
                        state_d = S_FINISH;
                    end else begin
                        bin_d    = Value;
                        bcd_d    = '0;
                        bitcnt_d = '0;
                        ovfw_d   = 1'b0;
                        hexw_d   = 1'b0;
                        state_d  = S_SHIFT;
                    end
                end
            end
            S_SHIFT: begin
                // A one leaving the top nibble means the value needs more digits than we have
                ovfw_d   = ovfw_q | adj[BCD_W-1];
                bcd_d    = {adj[BCD_W-2:0], bin_q[BIN_W-1]};
                bin_d    = bin_q << 1;
                bitcnt_d = bitcnt_q + 1'b1;
                if (bitcnt_q == CNT_W'(BIN_W - 1)) begin
                    state_d = S_FINISH;
                end
            end
            S_FINISH: begin
                disp_d  = bcd_q;
                ovf_d   = ovfw_q & ~hexw_q;
                hexm_d  = hexw_q;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Scan timing: digit index advances each time the prescaler wraps
    always_comb begin
        scan_d = scan_q + 1'b1;
        idx_d  = idx_q;
        if (scan_d == '0) begin
            idx_d = (idx_q == IDX_W'(NUM_DIGITS - 1)) ? '0 : idx_q + 1'b1;
        end
    end

    // Segment/anode decode from next-cycle state so An and Seg always agree with the shown digit
    always_comb begin
        seg_d      = 7'b1111111;
        nib        = '0;
        zero_above = 1'b1;
        for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
            nib        = disp_d[4*k +: 4];
            zero_above = zero_above & (nib == 4'd0);
            if (idx_d == IDX_W'(k)) begin
                if (!hexm_d && ovf_d) begin
                    seg_d = 7'b1111110;
                end else if (BLANK_LZ && !hexm_d && (k != 0) && zero_above) begin
                    seg_d = 7'b1111111;
                end else begin
                    seg_d = hex_glyph(nib);
                end
            end
        end
        an_d = Blank ? '1 : ~(NUM_DIGITS'(1) << idx_d);
    end

    // Conversion state and display register
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q  <= S_IDLE;
            bin_q    <= '0;
            bcd_q    <= '0;
            bitcnt_q <= '0;
            ovfw_q   <= 1'b0;
            hexw_q   <= 1'b0;
            disp_q   <= '0;
            ovf_q    <= 1'b0;
            hexm_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            bin_q    <= bin_d;
            bcd_q    <= bcd_d;
            bitcnt_q <= bitcnt_d;
            ovfw_q   <= ovfw_d;
            hexw_q   <= hexw_d;
            disp_q   <= disp_d;
            ovf_q    <= ovf_d;
            hexm_q   <= hexm_d;
        end
    end

    // Scan counter and registered anode/cathode drive
    always_ff @(posedge Clk) begin
        if (Reset) begin
            scan_q <= '0;
            idx_q  <= '0;
            an_q   <= ~NUM_DIGITS'(1);
            seg_q  <= 7'b0000001;
        end else begin
            scan_q <= scan_d;
            idx_q  <= idx_d;
            an_q   <= an_d;
            seg_q  <= seg_d;
        end
    end

    assign Busy     = (state_q == S_SHIFT);
    assign Done     = (state_q == S_FINISH);
    assign Overflow = ovf_q;
    assign An       = an_q;
    assign Seg      = seg_q;
    assign Dp       = 1'b1;

endmodule

// File: tb/tb_ssd_bcd_scan_display.sv
// tb/tb_ssd_bcd_scan_display.sv - self-checking bench for ssd_bcd_scan_display
module tb_ssd_bcd_scan_display;

    logic       clk = 1'b0;
    logic       Reset = 1'b1;
    logic       Load = 1'b0;
    logic       Hex_Mode = 1'b0;
    logic       Blank = 1'b0;
    logic [7:0] Value = 8'd0;

    always #5 clk = ~clk;

    logic       busy3, done3, ovf3, dp3;
    logic [2:0] an3;
    logic [6:0] seg3;
    logic       busy3n, done3n, ovf3n, dp3n;
    logic [2:0] an3n;
    logic [6:0] seg3n;
    logic       busy2, done2, ovf2, dp2;
    logic [1:0] an2;
    logic [6:0] seg2;

    ssd_bcd_scan_display #(.BIN_W(8), .NUM_DIGITS(3), .SCAN_DIV(2), .BLANK_LZ(1'b1)) dut3 (
        .Clk(clk), .Reset(Reset), .Value(Value), .Load(Load), .Hex_Mode(Hex_Mode), .Blank(Blank),
        .Busy(busy3), .Done(done3), .Overflow(ovf3), .An(an3), .Seg(seg3), .Dp(dp3));

    ssd_bcd_scan_display #(.BIN_W(8), .NUM_DIGITS(3), .SCAN_DIV(2), .BLANK_LZ(1'b0)) dut3n (
        .Clk(clk), .Reset(Reset), .Value(Value), .Load(Load), .Hex_Mode(Hex_Mode), .Blank(Blank),
        .Busy(busy3n), .Done(done3n), .Overflow(ovf3n), .An(an3n), .Seg(seg3n), .Dp(dp3n));

    ssd_bcd_scan_display #(.BIN_W(8), .NUM_DIGITS(2), .SCAN_DIV(2), .BLANK_LZ(1'b1)) dut2 (
        .Clk(clk), .Reset(Reset), .Value(Value), .Load(Load), .Hex_Mode(Hex_Mode), .Blank(Blank),
        .Busy(busy2), .Done(done2), .Overflow(ovf2), .An(an2), .Seg(seg2), .Dp(dp2));

    int n_checks = 0;
    int n_fail   = 0;

    logic [6:0] tab [16] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
                             7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
                             7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
                             7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000};

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0h required=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic int pow10(input int n);
        int p = 1;
        for (int i = 0; i < n; i++) p = p * 10;
        return p;
    endfunction

    function automatic logic [6:0] exp_seg(input int val, input bit hx, input int n, input bit lz, input int k);
        if (hx) return tab[(val >> (4 * k)) & 15];
        if (val >= pow10(n)) return 7'b1111110;
        if (lz && k > 0 && (val / pow10(k)) == 0) return 7'b1111111;
        return tab[(val / pow10(k)) % 10];
    endfunction

    // Inputs as seen by the DUT at each rising edge
    logic       s_valid = 1'b0;
    logic       s_rst, s_load, s_hex, s_blank;
    logic [7:0] s_val;
    always @(posedge clk) begin
        s_valid <= 1'b1;
        s_rst   <= Reset;
        s_load  <= Load;
        s_hex   <= Hex_Mode;
        s_blank <= Blank;
        s_val   <= Value;
    end

    // Reference model: m_rem = cycles until publish (-1 idle, 0 = publish cycle)
    int m_rem = -1, m_val = 0, p_val = 0, m_cnt = 0, m_idx3 = 0, m_idx2 = 0;
    bit m_hex = 1'b0, p_hex = 1'b0;

    initial begin
        logic [2:0] e_an3;
        logic [1:0] e_an2;
        bit         blk;
        forever begin
            @(negedge clk);
            if (s_valid) begin
                if (s_rst) begin
                    m_rem = -1; m_val = 0; m_hex = 1'b0; m_cnt = 0; m_idx3 = 0; m_idx2 = 0;
                end else begin
                    if (m_rem == 0) begin
                        m_val = p_val; m_hex = p_hex; m_rem = -1;
                    end else if (m_rem > 0) begin
                        m_rem--;
                    end else if (s_load) begin
                        p_val = int'(s_val); p_hex = s_hex; m_rem = s_hex ? 0 : 8;
                    end
                    m_cnt = (m_cnt + 1) % 4;
                    if (m_cnt == 0) begin
                        m_idx3 = (m_idx3 + 1) % 3;
                        m_idx2 = (m_idx2 + 1) % 2;
                    end
                end
                blk   = s_blank && !s_rst;
                e_an3 = blk ? 3'b111 : ~(3'b001 << m_idx3);
                e_an2 = blk ? 2'b11  : ~(2'b01 << m_idx2);
                chk("d3_busy", busy3, m_rem > 0);
                chk("d3_done", done3, m_rem == 0);
                chk("d3_ovf", ovf3, !m_hex && m_val >= 1000);
                chk("d3_an", an3, e_an3);
                chk("d3_seg", seg3, exp_seg(m_val, m_hex, 3, 1'b1, m_idx3));
                chk("d3_dp", dp3, 1'b1);
                chk("d3n_busy", busy3n, m_rem > 0);
                chk("d3n_done", done3n, m_rem == 0);
                chk("d3n_an", an3n, e_an3);
                chk("d3n_seg", seg3n, exp_seg(m_val, m_hex, 3, 1'b0, m_idx3));
                chk("d2_busy", busy2, m_rem > 0);
                chk("d2_done", done2, m_rem == 0);
                chk("d2_ovf", ovf2, !m_hex && m_val >= 100);
                chk("d2_an", an2, e_an2);
                chk("d2_seg", seg2, exp_seg(m_val, m_hex, 2, 1'b1, m_idx2));
            end
        end
    end

    logic [6:0] cap3 [3];
    logic [6:0] cap3n [3];
    logic [6:0] cap2 [2];

    task automatic scan_digits();
        for (int i = 0; i < 3; i++) begin
            cap3[i] = 'x;
            cap3n[i] = 'x;
        end
        cap2[0] = 'x;
        cap2[1] = 'x;
        for (int c = 0; c < 16; c++) begin
            @(negedge clk);
            for (int i = 0; i < 3; i++) begin
                if (an3 == ~(3'b001 << i)) cap3[i] = seg3;
                if (an3n == ~(3'b001 << i)) cap3n[i] = seg3n;
            end
            for (int i = 0; i < 2; i++) begin
                if (an2 == ~(2'b01 << i)) cap2[i] = seg2;
            end
        end
    endtask

    task automatic do_load(input logic [7:0] v, input logic hx, input int exp_cyc,
                           input int exp_busy, input string nm);
        int cyc, busy_n;
        Value = v; Hex_Mode = hx; Load = 1'b1;
        @(negedge clk);
        Load = 1'b0;
        cyc = 1; busy_n = 0;
        while (!done3 && cyc < 40) begin
            if (busy3) busy_n++;
            @(negedge clk);
            cyc++;
        end
        chk({nm, "_done_cycle"}, cyc, exp_cyc);
        chk({nm, "_busy_cycles"}, busy_n, exp_busy);
        @(negedge clk);
    endtask

    initial begin
        int cyc;
        repeat (3) @(negedge clk);
        Reset = 1'b0;
        chk("rst_an", an3, 3'b110);
        chk("rst_seg", seg3, 7'b0000001);
        chk("rst_busy", busy3, 1'b0);
        repeat (4) @(negedge clk);
        chk("scan1_an", an3, 3'b101);
        chk("scan1_seg", seg3, 7'b1111111);

        do_load(8'd225, 1'b0, 9, 8, "d225");
        scan_digits();
        chk("d225_dig0", cap3[0], 7'b0100100);
        chk("d225_dig1", cap3[1], 7'b0010010);
        chk("d225_dig2", cap3[2], 7'b0010010);
        chk("d225_ovf", ovf3, 1'b0);

        do_load(8'd7, 1'b0, 9, 8, "d7");
        scan_digits();
        chk("d7_dig0", cap3[0], 7'b0001111);
        chk("d7_dig1", cap3[1], 7'b1111111);
        chk("d7_dig2", cap3[2], 7'b1111111);
        chk("d7_nolz_dig1", cap3n[1], 7'b0000001);
        chk("d7_nolz_dig2", cap3n[2], 7'b0000001);

        do_load(8'hAB, 1'b1, 1, 0, "hexab");
        scan_digits();
        chk("hexab_dig0", cap3[0], 7'b1100000);
        chk("hexab_dig1", cap3[1], 7'b0001000);
        chk("hexab_dig2", cap3[2], 7'b0000001);

        do_load(8'd150, 1'b0, 9, 8, "d150");
        chk("d150_ovf2", ovf2, 1'b1);
        scan_digits();
        chk("d150_n2_dig0", cap2[0], 7'b1111110);
        chk("d150_n2_dig1", cap2[1], 7'b1111110);

        do_load(8'd42, 1'b0, 9, 8, "d42");
        chk("d42_ovf2", ovf2, 1'b0);
        scan_digits();
        chk("d42_n2_dig0", cap2[0], 7'b0010010);
        chk("d42_n2_dig1", cap2[1], 7'b1001100);

        Value = 8'd100; Hex_Mode = 1'b0; Load = 1'b1;
        @(negedge clk);
        cyc = 1;
        while (!done3 && cyc < 40) begin
            if (cyc == 3) begin
                Load = 1'b1; Value = 8'd55;
            end else begin
                Load = 1'b0;
            end
            @(negedge clk);
            cyc++;
        end
        Load = 1'b0;
        chk("reload_done_cycle", cyc, 9);
        @(negedge clk);
        scan_digits();
        chk("reload_dig0", cap3[0], 7'b0000001);
        chk("reload_dig1", cap3[1], 7'b0000001);
        chk("reload_dig2", cap3[2], 7'b1001111);

        Value = 8'd200; Load = 1'b1;
        @(negedge clk);
        Load = 1'b0;
        repeat (2) @(negedge clk);
        Reset = 1'b1;
        @(negedge clk);
        Reset = 1'b0;
        chk("abort_busy", busy3, 1'b0);
        chk("abort_an", an3, 3'b110);
        chk("abort_seg", seg3, 7'b0000001);

        for (int c = 0; c < 1500; c++) begin
            Load     = ($urandom_range(0, 5) == 0);
            Hex_Mode = ($urandom_range(0, 3) == 0);
            Blank    = ($urandom_range(0, 7) == 0);
            Reset    = ($urandom_range(0, 149) == 0);
            Value    = ($urandom_range(0, 2) == 0) ? 8'($urandom_range(0, 15)) : 8'($urandom_range(0, 255));
            @(negedge clk);
        end
        Load = 1'b0; Reset = 1'b0; Blank = 1'b0;
        repeat (12) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
